// File: rtl/module_divider_seq.sv
// Sequential restoring divider, one shift/subtract iteration per bit, init/step/done control.
// Define SIGNED_DIV_EN for two's-complement operands (adds sign fix-up state FIX).
module module_divider_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             step,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [6:0] {
    IDLE  = 7'b0000001,
    LOAD  = 7'b0000010,
    SHIFT = 7'b0000100,
    SUB   = 7'b0001000,
    CHECK = 7'b0010000,
    DONE  = 7'b0100000
`ifdef SIGNED_DIV_EN
    , FIX = 7'b1000000
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd_load;
  logic [WIDTH-1:0] dvs_load;

`ifdef SIGNED_DIV_EN
  logic sign_q;
  logic sign_r;

  // The most negative value maps to itself, which reads correctly as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  assign dvd_load = mag(dividend);
  assign dvs_load = mag(divisor);
`else
  assign dvd_load = dividend;
  assign dvs_load = divisor;
`endif

  assign trial = r - {1'b0, d};

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (init) state_nxt = LOAD;
      LOAD:  state_nxt = (divisor == '0) ? DONE : SHIFT;
      SHIFT: state_nxt = SUB;
      SUB:   state_nxt = CHECK;
`ifdef SIGNED_DIV_EN
      CHECK: state_nxt = (count == '0) ? FIX : SHIFT;
      FIX:   state_nxt = DONE;
`else
      CHECK: state_nxt = (count == '0) ? DONE : SHIFT;
`endif
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    step = (state == SUB);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r           <= '0;
      d           <= '0;
      q           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          d     <= dvs_load;
          q     <= dvd_load;
          r     <= '0;
          count <= CW'(WIDTH);
`ifdef SIGNED_DIV_EN
          sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sign_r <= dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            div_by_zero <= 1'b1;
            quotient    <= '1;
            remainder   <= dividend;
          end else begin
            div_by_zero <= 1'b0;
          end
        end
        SHIFT: {r, q} <= {r[WIDTH-1:0], q, 1'b0};
        SUB: begin
          if (!trial[WIDTH]) begin
            r    <= trial;
            q[0] <= 1'b1;
          end else begin
            q[0] <= 1'b0;
          end
          count <= count - CW'(1);
        end
        CHECK: begin
          if (count == '0) begin
            quotient  <= q;
            remainder <= r[WIDTH-1:0];
          end
        end
`ifdef SIGNED_DIV_EN
        FIX: begin
          if (sign_q) quotient  <= ~quotient + WIDTH'(1);
          if (sign_r) remainder <= ~remainder + WIDTH'(1);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_module_divider_seq.sv
// Directed and reference-model checks for module_divider_seq at WIDTH=8.
// Build with SIGNED_DIV_EN defined to exercise the signed fix-up path.
module tb_module_divider_seq;

  logic       clk;
  logic       rst;
  logic       init;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       step;
  logic       done;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

`ifdef SIGNED_DIV_EN
  localparam int LAT = 27;
`else
  localparam int LAT = 26;
`endif

  module_divider_seq #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .step       (step),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Start one operation from IDLE; cycle k is the interval after the k-th edge following init.
  task automatic run_op(input logic [7:0] dvd, input logic [7:0] dvs,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz,
                        input int elat, input int esteps, input int pulse_at);
    int lat;
    int steps;
    int busy_low;
    lat = 0;
    steps = 0;
    busy_low = 0;
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    init     = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      init = (k == pulse_at);
      if (step) steps++;
      if (!busy) busy_low++;
      if (done) begin
        lat = k;
        break;
      end
    end
    init = 1'b0;
    check("latency", lat, elat);
    check("step_count", steps, esteps);
    check("busy_low_during_op", busy_low, 0);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, edz);
    @(posedge clk);
    #1;
    check("idle_after_done", busy, 1'b0);
    check("done_single_pulse", done, 1'b0);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    rst = 1'b0;
    init = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_quotient", quotient, 8'd0);
    check("rst_remainder", remainder, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_step", step, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    rst = 1'b1;

    run_op(8'd100, 8'd7,  8'd14,   8'd2,    1'b0, LAT, 8, 0);
    run_op(8'd5,   8'd0,  8'hFF,   8'h05,   1'b1, 2,   0, 0);
    run_op(8'd3,   8'd10, 8'd0,    8'd3,    1'b0, LAT, 8, 0);
    run_op(8'd255, 8'd1,  8'hFF,   8'h00,   1'b0, LAT, 8, 0);
`ifdef SIGNED_DIV_EN
    run_op(8'd200, 8'd9,  8'hFA,   8'hFE,   1'b0, LAT, 8, 5);
`else
    run_op(8'd200, 8'd9,  8'd22,   8'd2,    1'b0, LAT, 8, 5);
`endif

    // Abort mid-operation with reset at cycle 10.
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd3;
    init     = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy_before_abort", busy, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_quotient", quotient, 8'd0);
    check("abort_remainder", remainder, 8'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_step", step, 1'b0);
    check("abort_dbz", div_by_zero, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_stays_idle", busy, 1'b0);

`ifdef SIGNED_DIV_EN
    run_op(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, LAT, 8, 0);
    run_op(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, LAT, 8, 0);
    run_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT, 8, 0);
    run_op(8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 2,   0, 0);
`else
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_op(a, b, a / b, a % b, 1'b0, LAT, 8, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
